iterative_divider: RTL and testbench

- Multi-cycle radix-2 restoring integer divider, the inverse of the single-cycle combinational multiplier in the execute stage.
- Serves DIV/DIVU in the pipelined MIPS core: the execute stage issues a start, stalls on busy, and writes the quotient to LO and the remainder to HI when done pulses.
- Supports signed and unsigned operation with a deterministic divide-by-zero result.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_sign_fix.sv | 15 +
 rtl/iterative_divider.sv | 153 +++++++++++++++
 tb/tb_iterative_divider.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants for the iterative divider: FSM state encodings and
// the fixed quotient reported on a divide by zero.
package div_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Sliced down to DATA_WIDTH by the user, so widths up to 64 are covered.
  localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to apply the final sign to quotient and remainder.
module div_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value_i,
  input  logic         negate_i,
  output logic [W-1:0] result_o
);

  // Negating -2^(W-1) yields the same bit pattern, which read as unsigned is
  // exactly the magnitude 2^(W-1).
  assign result_o = negate_i ? (~value_i + {{(W-1){1'b0}}, 1'b1}) : value_i;

endmodule

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign-corrected results registered on the final iteration.
module iterative_divider
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero,
  output logic [1:0]            dbg_state_o
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   quo_q, quo_d;
  logic [DATA_WIDTH-1:0]   dvs_q, dvs_d;
  logic                    q_neg_q, q_neg_d;
  logic                    r_neg_q, r_neg_d;
  logic [DATA_WIDTH-1:0]   quotient_q, quotient_d;
  logic [DATA_WIDTH-1:0]   remainder_q, remainder_d;
  logic                    dbz_q, dbz_d;

  logic                    accept;
  logic                    dividend_neg, divisor_neg;
  logic [DATA_WIDTH-1:0]   dividend_mag, divisor_mag;
  logic [DATA_WIDTH:0]     rem_shift;
  logic                    trial_ok;
  logic [DATA_WIDTH-1:0]   trial_diff;
  logic [DATA_WIDTH-1:0]   rem_next, quo_next;
  logic [DATA_WIDTH-1:0]   quo_fixed, rem_fixed;

  assign accept       = start && (state_q != S_RUN);
  assign dividend_neg = is_signed && dividend[DATA_WIDTH-1];
  assign divisor_neg  = is_signed && divisor[DATA_WIDTH-1];

  div_sign_fix #(.W(DATA_WIDTH)) u_abs_dividend (
    .value_i(dividend), .negate_i(dividend_neg), .result_o(dividend_mag)
  );
  div_sign_fix #(.W(DATA_WIDTH)) u_abs_divisor (
    .value_i(divisor), .negate_i(divisor_neg), .result_o(divisor_mag)
  );

  // The trial subtraction only matters through its sign, so it is done as an
  // unsigned compare; when it succeeds the difference is below the divisor
  // and the modular DATA_WIDTH-bit subtraction is exact.
  assign rem_shift  = {rem_q, quo_q[DATA_WIDTH-1]};
  assign trial_ok   = rem_shift >= {1'b0, dvs_q};
  assign trial_diff = rem_shift[DATA_WIDTH-1:0] - dvs_q;
  assign rem_next   = trial_ok ? trial_diff : rem_shift[DATA_WIDTH-1:0];
  assign quo_next   = {quo_q[DATA_WIDTH-2:0], trial_ok};

  div_sign_fix #(.W(DATA_WIDTH)) u_fix_quotient (
    .value_i(quo_next), .negate_i(q_neg_q), .result_o(quo_fixed)
  );
  div_sign_fix #(.W(DATA_WIDTH)) u_fix_remainder (
    .value_i(rem_next), .negate_i(r_neg_q), .result_o(rem_fixed)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_RUN: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == LAST_CNT) begin
          state_d     = S_DONE;
          quotient_d  = quo_fixed;
          remainder_d = rem_fixed;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Acceptance from IDLE or DONE overrides the default transition above.
    if (accept) begin
      quotient_d  = '0;
      remainder_d = '0;
      dbz_d       = 1'b0;
      q_neg_d     = dividend_neg ^ divisor_neg;
      r_neg_d     = dividend_neg;
      dvs_d       = divisor_mag;
      quo_d       = dividend_mag;
      rem_d       = '0;
      cnt_d       = '0;
      if (divisor == '0) begin
        state_d     = S_DONE;
        quotient_d  = DIV_ZERO_QUOTIENT[DATA_WIDTH-1:0];
        remainder_d = dividend;
        dbz_d       = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed bench for iterative_divider: driver tasks push hand-computed
// results into a scoreboard queue that a negedge monitor checks on done.
module tb_iterative_divider;

  localparam int W = 32;

  // Handshake: a start driven at a negedge is sampled on the next rising edge
  // and accepted only when busy=0; done is a one-cycle pulse carrying results.

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Expected entry: {div_by_zero, remainder, quotient} plus the cycle of done.
  logic [2*W:0] exp_q[$];
  int           exp_cyc_q[$];

  iterative_divider #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .dbg_state_o(dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; leaves start low at the negedge after acceptance.
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_quo, input logic [W-1:0] exp_rem,
                       input logic exp_dbz);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    exp_q.push_back({exp_dbz, exp_rem, exp_quo});
    exp_cyc_q.push_back(cyc + 1 + ((b == '0) ? 0 : W));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 64'(busy), 64'(b != '0));
  endtask

  task automatic wait_done();
    logic seen;
    seen = done;
    for (int i = 0; i < 2 * W && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", 2 * W);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (quotient 0x%0h)", quotient);
      end else begin
        logic [2*W:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("quotient", 64'(quotient), 64'(e[W-1:0]));
        check("remainder", 64'(remainder), 64'(e[2*W-1:W]));
        check("div_by_zero", 64'(div_by_zero), 64'(e[2*W]));
        check("done_cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    check("reset_state", 64'(dbg_state), 64'(0));
    check("reset_outputs", {29'd0, busy, done, div_by_zero, quotient}, 64'(0));
    check("reset_remainder", 64'(remainder), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned and signed basics
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);                     wait_done(); @(negedge clk);
    issue(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);    wait_done(); @(negedge clk);
    issue(1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0);         wait_done(); @(negedge clk);
    issue(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0);   wait_done(); @(negedge clk);
    issue(1'b0, 32'd7, 32'd100, 32'd0, 32'd7, 1'b0);                       wait_done(); @(negedge clk);

    // Divide by zero, unsigned and signed
    issue(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1);    wait_done(); @(negedge clk);
    issue(1'b1, 32'h80000001, 32'd0, 32'hFFFFFFFF, 32'h80000001, 1'b1);    wait_done(); @(negedge clk);

    // Overflow and extremes
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);    wait_done(); @(negedge clk);
    issue(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);           wait_done(); @(negedge clk);
    issue(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);    wait_done(); @(negedge clk);
    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);           wait_done(); @(negedge clk);

    // Start during RUN is ignored; start in the DONE cycle is accepted
    issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd5;
    divisor  = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 1'b0);
    wait_done();
    // Back-to-back from DONE into a divide by zero
    issue(1'b0, 32'd77, 32'd0, 32'hFFFFFFFF, 32'd77, 1'b1);
    wait_done(); @(negedge clk);

    // Reset in the middle of a division abandons it
    issue(1'b0, 32'd50000, 32'd7, 32'd7142, 32'd6, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_state", 64'(dbg_state), 64'(0));
    check("midreset_busy_done", {62'd0, busy, done}, 64'(0));
    check("midreset_results", {31'd0, div_by_zero, quotient}, 64'(0));
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * W) @(negedge clk);
    issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    wait_done(); @(negedge clk);

    // Results hold while idle
    repeat (5) @(negedge clk);
    check("hold_quotient", 64'(quotient), 64'(3));
    check("hold_state", 64'(dbg_state), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
